msg_serial_tx: RTL and testbench

//  Parametrised message serialiser: the successor to the lab top-level's fixed 5-bit msg/SW/mode/start path.
//  - Buffers up to DEPTH messages in a FIFO.
//  - Shifts each message out one bit per programmable period (SW+1 clocks), LSB- or MSB-first.
//  - Optional continuous repeat of the last message.
//  - Drives the serial line and status/display outputs.

---
 rtl/msg_serial_tx_pkg.sv | 21 ++
 rtl/msg_serial_tx_fifo.sv | 65 ++++++
 rtl/msg_serial_tx.sv | 162 ++++++++++++++++
 tb/tb_msg_serial_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_serial_tx_pkg.sv
// Shared definitions for the message serialiser.
//   tx_state_e : transmitter FSM states (IDLE -> LOAD -> SHIFT -> DONE)
//   sel_bit    : picks the bit currently on the line from a shift register
//                edge (LSB end for LSB-first, MSB end for MSB-first).
package msg_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  // Returns msb_end when MSB-first, lsb_end otherwise.
  function automatic logic sel_bit(input logic msb_first,
                                   input logic lsb_end,
                                   input logic msb_end);
    return msb_first ? msb_end : lsb_end;
  endfunction

endpackage

// File: rtl/msg_serial_tx_fifo.sv
// Synchronous message FIFO with show-ahead read.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous flush (same effect on pointers/count as rst)
//   push/pop   : enqueue / dequeue requests (ignored when full / empty)
//   wr_data    : data to enqueue
//   rd_data    : head of queue, valid whenever empty=0
//   full/empty : status flags
//   count      : number of entries held
// The head is read combinationally so the transmitter can load and pop in
// the same cycle; the store is tiny, so a distributed array is intended.
module msg_serial_tx_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/msg_serial_tx.sv
// Parametrised message serialiser.
//   clk, rst    : clock, synchronous active-high reset
//   init        : soft clear (flush FIFO, abort frame, keep out)
//   SW          : bit period minus one, latched at LOAD
//   msg, msg_valid, msg_ready : enqueue handshake
//   mode        : 0 LSB-first, 1 MSB-first, latched at LOAD
//   sel         : 1 repeats the last frame while the FIFO is empty
//   start       : arms the transmitter
//   tx_bit, tx_strobe : serial data and first-clock-of-bit strobe
//   busy, done  : activity flag and end-of-frame pulse
//   fifo_count  : queued messages
//   out         : copy of the frame being / last transmitted
module msg_serial_tx
  import msg_serial_tx_pkg::*;
#(
  parameter int MSG_W = 5,
  parameter int DIV_W = 10,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic [DIV_W-1:0]        SW,
  input  logic [MSG_W-1:0]        msg,
  input  logic                    msg_valid,
  output logic                    msg_ready,
  input  logic                    mode,
  input  logic                    sel,
  input  logic                    start,
  output logic                    tx_bit,
  output logic                    tx_strobe,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [MSG_W-1:0]        out
);

  localparam int CNT_W = $clog2(MSG_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_W - 1);

  tx_state_e        state_reg, state_next;
  logic             run_reg;
  logic [MSG_W-1:0] shift_reg;
  logic [MSG_W-1:0] out_reg;
  logic [DIV_W-1:0] d_reg;
  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] bit_reg;
  logic             mode_reg;

  logic [MSG_W-1:0] fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [MSG_W-1:0] load_data;
  logic             bit_end;
  logic             frame_end;

  msg_serial_tx_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (init),
    .push    (msg_valid && !init),
    .pop     (fifo_pop),
    .wr_data (msg),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign msg_ready = !fifo_full;
  assign out       = out_reg;
  assign bit_end   = (div_reg == d_reg);
  assign frame_end = bit_end && (bit_reg == LAST_BIT);
  // An empty FIFO at LOAD means this is a repeat of the previous frame.
  assign load_data = fifo_empty ? out_reg : fifo_rd_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst || init) state_reg <= ST_IDLE;
    else             state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if ((start || run_reg) && !fifo_empty) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: if (frame_end) state_next = ST_DONE;
      ST_DONE:  state_next = (!fifo_empty || sel) ? ST_LOAD : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_bit    = 1'b0;
    tx_strobe = 1'b0;
    busy      = (state_reg != ST_IDLE);
    done      = (state_reg == ST_DONE);
    fifo_pop  = (state_reg == ST_LOAD) && !fifo_empty;
    if (state_reg == ST_SHIFT) begin
      tx_bit    = sel_bit(mode_reg, shift_reg[0], shift_reg[MSG_W-1]);
      tx_strobe = (div_reg == '0);
    end
  end

  // run stays set until a DONE finds nothing more to send; a fresh start
  // in the same cycle re-arms it.
  always_ff @(posedge clk) begin
    if (rst || init)
      run_reg <= 1'b0;
    else if (start)
      run_reg <= 1'b1;
    else if (state_reg == ST_DONE && state_next == ST_IDLE)
      run_reg <= 1'b0;
  end

  // Datapath: divider, bit counter, shift register, latched parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      out_reg   <= '0;
      d_reg     <= '0;
      mode_reg  <= 1'b0;
      div_reg   <= '0;
      bit_reg   <= '0;
    end else if (init) begin
      shift_reg <= '0;
      div_reg   <= '0;
      bit_reg   <= '0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          shift_reg <= load_data;
          out_reg   <= load_data;
          d_reg     <= SW;
          mode_reg  <= mode;
          div_reg   <= '0;
          bit_reg   <= '0;
        end
        ST_SHIFT: begin
          if (!bit_end) begin
            div_reg <= div_reg + 1'b1;
          end else if (bit_reg != LAST_BIT) begin
            div_reg   <= '0;
            bit_reg   <= bit_reg + 1'b1;
            shift_reg <= mode_reg ? {shift_reg[MSG_W-2:0], 1'b0}
                                  : {1'b0, shift_reg[MSG_W-1:1]};
          end
          // On the final clock both counters hold at their terminal values.
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_serial_tx.sv
module tb_msg_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init = 1'b0;
  logic [9:0] SW = '0;
  logic [4:0] msg = '0;
  logic       msg_valid = 1'b0;
  logic       msg_ready;
  logic       mode = 1'b0;
  logic       sel = 1'b0;
  logic       start = 1'b0;
  logic       tx_bit;
  logic       tx_strobe;
  logic       busy;
  logic       done;
  logic [2:0] fifo_count;
  logic [4:0] out;

  int checks = 0;
  int failures = 0;

  msg_serial_tx #(.MSG_W(5), .DIV_W(10), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .SW         (SW),
    .msg        (msg),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .mode       (mode),
    .sel        (sel),
    .start      (start),
    .tx_bit     (tx_bit),
    .tx_strobe  (tx_strobe),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count),
    .out        (out)
  );

  always #5 clk = ~clk;

  // Frame plan consumed by run_timeline: transmitted-bit pattern (index i =
  // i-th bit on the line), message copy, divider value and order per frame.
  logic [4:0] f_pat [8];
  logic [4:0] f_msg [8];
  int         f_d   [8];
  logic       f_mode[8];
  int         nfr;
  int         q0;
  int         sel_drop;
  logic [4:0] out_before;

  typedef struct {
    logic [4:0] msg;
    int         d;
    logic       mode;
    logic [4:0] pat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_msg(input logic [4:0] m);
    msg = m;
    msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0;
  endtask

  function automatic logic [4:0] line_order(input logic [4:0] m, input logic msb_first);
    logic [4:0] p;
    for (int i = 0; i < 5; i++) p[i] = msb_first ? m[4-i] : m[i];
    return p;
  endfunction

  // Pulses start, then checks every cycle against a timeline derived from
  // the frame plan: LOAD, 5*(D+1) SHIFT clocks, DONE, next LOAD ...
  task automatic run_timeline();
    int L[8];
    int F[8];
    int endc;
    L[0] = 1;
    for (int f = 0; f < nfr; f++) begin
      F[f] = 5 * (f_d[f] + 1);
      if (f > 0) L[f] = L[f-1] + F[f-1] + 2;
    end
    endc = L[nfr-1] + F[nfr-1] + 1 + 2;
    SW = 10'(f_d[0]);
    mode = f_mode[0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= endc; c++) begin
      int f_in = -1;
      int rel = 0;
      int pops = 0;
      logic e_tx = 1'b0, e_st = 1'b0, e_busy = 1'b0, e_done = 1'b0;
      logic [4:0] e_out = out_before;
      for (int f = 0; f < nfr; f++)
        if (c >= L[f] && c <= L[f] + F[f] + 1) begin
          f_in = f;
          rel = c - L[f];
        end
      if (f_in >= 0) begin
        e_busy = 1'b1;
        if (rel >= 1 && rel <= F[f_in]) begin
          int s = rel - 1;
          int i = s / (f_d[f_in] + 1);
          int j = s % (f_d[f_in] + 1);
          e_tx = f_pat[f_in][i];
          e_st = (j == 0);
        end else if (rel == F[f_in] + 1) begin
          e_done = 1'b1;
        end
      end
      for (int f = 0; f < nfr; f++)
        if (L[f] < c) begin
          if (f < q0) pops++;
          e_out = f_msg[f];
        end
      if (f_in >= 0 && rel == 0)
        $display("frame %0d msg=%b D=%0d mode=%0b queued=%0d", f_in, f_msg[f_in],
                 f_d[f_in], f_mode[f_in], q0);
      chk("tx_strobe_busy_done", c, 32'({tx_bit, tx_strobe, busy, done}),
          32'({e_tx, e_st, e_busy, e_done}));
      chk("count_out", c, 32'({fifo_count, out}), 32'({3'(q0 - pops), e_out}));
      // Mid-frame parameter changes aim at the following frame only.
      if (f_in >= 0 && rel == 2) begin
        if (f_in + 1 < nfr) begin
          SW = 10'(f_d[f_in + 1]);
          mode = f_mode[f_in + 1];
        end else begin
          SW = 10'($urandom_range(9, 0));
          mode = ~mode;
        end
        if (f_in == sel_drop) sel = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0] = '{5'b10101, 3, 1'b0, 5'b10101};
    vecs[1] = '{5'b10011, 0, 1'b1, 5'b11001};
    vecs[2] = '{5'b00001, 1, 1'b1, 5'b10000};
    vecs[3] = '{5'b11010, 2, 1'b0, 5'b11010};
    vecs[4] = '{5'b01100, 0, 1'b1, 5'b00110};

    // Reset state
    do_reset();
    chk("reset_outputs", 0, 32'({tx_bit, tx_strobe, busy, done, msg_ready}), 32'(5'b00001));
    chk("reset_count_out", 0, 32'({fifo_count, out}), 32'h0);

    // Single-frame table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      push_msg(vecs[v].msg);
      nfr = 1; q0 = 1; sel_drop = -1; sel = 1'b0; out_before = '0;
      f_pat[0] = vecs[v].pat; f_msg[0] = vecs[v].msg;
      f_d[0] = vecs[v].d; f_mode[0] = vecs[v].mode;
      run_timeline();
    end

    // Full FIFO, fifth push dropped, four frames in order
    do_reset();
    for (int k = 0; k < 4; k++) push_msg(5'(k * 7 + 3));
    chk("full_ready", 0, 32'(msg_ready), 32'(0));
    chk("full_count", 0, 32'(fifo_count), 32'(4));
    push_msg(5'b11111);
    chk("drop_count", 0, 32'(fifo_count), 32'(4));
    nfr = 4; q0 = 4; sel_drop = -1; sel = 1'b0; out_before = '0;
    for (int k = 0; k < 4; k++) begin
      f_msg[k] = 5'(k * 7 + 3); f_d[k] = 2; f_mode[k] = 1'b0;
      f_pat[k] = line_order(f_msg[k], 1'b0);
    end
    run_timeline();

    // Repeat mode, dropped during the third frame
    do_reset();
    push_msg(5'b11000);
    sel = 1'b1;
    nfr = 3; q0 = 1; sel_drop = 2; out_before = '0;
    for (int k = 0; k < 3; k++) begin
      f_msg[k] = 5'b11000; f_d[k] = 1; f_mode[k] = 1'b0;
      f_pat[k] = 5'b11000;
    end
    run_timeline();
    push_msg(5'b00111);
    repeat (3) @(posedge clk);
    #1;
    chk("run_cleared_busy", 0, 32'(busy), 32'(0));

    // Divider and mode change mid-frame
    do_reset();
    push_msg(5'b10110);
    push_msg(5'b01101);
    nfr = 2; q0 = 2; sel_drop = -1; sel = 1'b0; out_before = '0;
    f_msg[0] = 5'b10110; f_d[0] = 3; f_mode[0] = 1'b0; f_pat[0] = 5'b10110;
    f_msg[1] = 5'b01101; f_d[1] = 7; f_mode[1] = 1'b1; f_pat[1] = 5'b10110;
    run_timeline();

    // init at bit 2: abort, flush, keep out
    do_reset();
    SW = 10'd3; mode = 1'b0;
    push_msg(5'b10101);
    push_msg(5'b01110);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("bit2_tx_strobe", 10, 32'({tx_bit, tx_strobe, busy}), 32'(3'b111));
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    chk("init_outputs", 11, 32'({tx_bit, tx_strobe, busy, done, msg_ready}), 32'(5'b00001));
    chk("init_count_out", 11, 32'({fifo_count, out}), 32'({3'd0, 5'b10101}));
    $display("init abort checked out=%b", out);
    for (int c = 0; c < 25; c++) begin
      chk("init_quiet", 12 + c, 32'({busy, done}), 32'(0));
      @(posedge clk); #1;
    end

    // rst mid-frame also clears out
    push_msg(5'b11111);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_outputs", 0, 32'({tx_bit, tx_strobe, busy, done, msg_ready}), 32'(5'b00001));
    chk("rst_count_out", 0, 32'({fifo_count, out}), 32'h0);
    $display("rst abort checked");

    // Randomised frames against the timeline model
    for (int t = 0; t < 6; t++) begin
      do_reset();
      nfr = $urandom_range(4, 1);
      q0 = nfr; sel_drop = -1; sel = 1'b0; out_before = '0;
      for (int k = 0; k < nfr; k++) begin
        f_msg[k] = 5'($urandom);
        f_d[k] = $urandom_range(4, 0);
        f_mode[k] = 1'($urandom);
        f_pat[k] = line_order(f_msg[k], f_mode[k]);
        push_msg(f_msg[k]);
      end
      run_timeline();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
